// File: rtl/cfg_pkg.sv
// Shared types, constants and helpers for the configuration-chain loader.
package cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef struct packed {
    logic [15:0] nwords;
    logic [15:0] pad;
  } cfg_geom_t;

  // Words per frame and the number of leading bits that fall off the chain tail.
  function automatic cfg_geom_t cfg_geom(input int chain_len, input int word_w);
    cfg_geom_t g;
    int        n;
    n        = (chain_len + word_w - 1) / word_w;
    g.nwords = 16'(n);
    g.pad    = 16'(n * word_w - chain_len);
    return g;
  endfunction

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Serial CRC-8 (poly 0x07, init 0x00), one bit per enabled cycle.
// Only instantiated by cfg_loader when CFG_LOADER_VERIFY_EN is defined.
module cfg_crc8
  import cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;

  // clr together with en restarts the CRC with the current bit already folded in.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else if (clr) begin
      crc_q <= en ? crc8_step(8'h00, bit_in) : 8'h00;
    end else if (en) begin
      crc_q <= crc8_step(crc_q, bit_in);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/cfg_loader.sv
// Streams paired words MSB-first into two connection-block configuration chains.
// Define CFG_LOADER_VERIFY_EN to build the recirculating CRC readback check.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_dataA,
  input  logic [WORD_W-1:0] s_dataB,
  input  logic              s_last,
  output logic              config_en,
  output logic              config_data_inA,
  output logic              config_data_inB,
  input  logic              config_data_outA,
  input  logic              config_data_outB,
  output logic              busy,
  output logic              done,
  output logic              err,
  output cfg_state_e        dbg_state_o
);

  localparam cfg_geom_t GEOM   = cfg_geom(CHAIN_LEN, WORD_W);
  localparam int        NWORDS = int'(GEOM.nwords);
  localparam int        BW     = $clog2(WORD_W + 1);
  localparam int        WCW    = $clog2(NWORDS + 1);

  // Handshake: a word transfers on a rising clk edge where s_valid and s_ready are
  // both high; s_ready is registered and only rises when the shifter is about to drain.
  cfg_state_e        state_q;
  logic [WORD_W-1:0] sh_a_q, sh_b_q;
  logic [BW-1:0]     bits_left_q;
  logic [WCW-1:0]    wcnt_q;
  logic              frame_end_q, ferr_q;
  logic              s_ready_q, en_q, din_a_q, din_b_q;
  logic              busy_q, done_q, err_q;

  logic              start_go, accept, last_bit, end_now, err_now;
  logic [WCW-1:0]    word_n;

  assign start_go = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
  assign accept   = (state_q == ST_LOAD) && s_valid && s_ready_q;
  assign word_n   = wcnt_q + 1'b1;
  assign end_now  = s_last || (word_n == WCW'(NWORDS));
  assign err_now  = s_last != (word_n == WCW'(NWORDS));
  assign last_bit = (state_q == ST_LOAD) && (bits_left_q == '0) && frame_end_q;

`ifdef CFG_LOADER_VERIFY_EN
  localparam int PAD = int'(GEOM.pad);
  localparam int VW  = $clog2(CHAIN_LEN + 1);
  localparam int SW  = $clog2(NWORDS * WORD_W + 1);

  logic [VW-1:0] vcnt_q;
  logic [SW-1:0] sent_q;
  logic [7:0]    ref_a_q, ref_b_q, crc_a, crc_b;
  logic          crc_clr, crc_en;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      bits_left_q <= '0;
      wcnt_q      <= '0;
      frame_end_q <= 1'b0;
      ferr_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      en_q        <= 1'b0;
      din_a_q     <= 1'b0;
      din_b_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef CFG_LOADER_VERIFY_EN
      vcnt_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_go) begin
            state_q     <= ST_LOAD;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            s_ready_q   <= 1'b1;
            en_q        <= 1'b0;
            wcnt_q      <= '0;
            bits_left_q <= '0;
            frame_end_q <= 1'b0;
            ferr_q      <= 1'b0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
          end
        end
        ST_LOAD: begin
          if (last_bit) begin
            s_ready_q <= 1'b0;
            en_q      <= 1'b0;
            if (ferr_q) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
`ifdef CFG_LOADER_VERIFY_EN
              state_q <= ST_VERIFY;
              en_q    <= 1'b1;
              vcnt_q  <= '0;
`else
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
`endif
            end
          end else if (accept) begin
            en_q        <= 1'b1;
            din_a_q     <= s_dataA[WORD_W-1];
            din_b_q     <= s_dataB[WORD_W-1];
            sh_a_q      <= s_dataA << 1;
            sh_b_q      <= s_dataB << 1;
            bits_left_q <= BW'(WORD_W - 1);
            wcnt_q      <= word_n;
            frame_end_q <= end_now;
            ferr_q      <= err_now;
            s_ready_q   <= (WORD_W == 1) && !end_now;
          end else if (bits_left_q != '0) begin
            en_q        <= 1'b1;
            din_a_q     <= sh_a_q[WORD_W-1];
            din_b_q     <= sh_b_q[WORD_W-1];
            sh_a_q      <= sh_a_q << 1;
            sh_b_q      <= sh_b_q << 1;
            bits_left_q <= bits_left_q - 1'b1;
            s_ready_q   <= (bits_left_q <= BW'(1)) && !frame_end_q;
          end else begin
            // Starved: hold the chain rather than shifting stale bits in.
            en_q      <= 1'b0;
            s_ready_q <= !frame_end_q;
          end
        end
`ifdef CFG_LOADER_VERIFY_EN
        ST_VERIFY: begin
          if (vcnt_q != VW'(CHAIN_LEN)) begin
            vcnt_q <= vcnt_q + 1'b1;
            if (vcnt_q == VW'(CHAIN_LEN - 1)) en_q <= 1'b0;
          end else if (crc_a == ref_a_q && crc_b == ref_b_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CFG_LOADER_VERIFY_EN
  // Recirculation must close the loop in the same cycle, so the tail bit bypasses the register.
  assign config_data_inA = (state_q == ST_VERIFY) ? config_data_outA : din_a_q;
  assign config_data_inB = (state_q == ST_VERIFY) ? config_data_outB : din_b_q;

  // Leading PAD bits fall off the chain, so they are kept out of the load-side CRC.
  assign crc_clr = start_go || (state_q == ST_VERIFY && vcnt_q == '0);
  assign crc_en  = en_q && ((state_q == ST_LOAD && sent_q >= SW'(PAD)) || state_q == ST_VERIFY);

  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      sent_q <= '0;
    end else if (state_q == ST_LOAD && en_q) begin
      sent_q <= sent_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_a_q <= 8'h00;
      ref_b_q <= 8'h00;
    end else if (state_q == ST_VERIFY && vcnt_q == '0) begin
      ref_a_q <= crc_a;
      ref_b_q <= crc_b;
    end
  end

  cfg_crc8 u_crc_a (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (config_data_inA),
    .crc    (crc_a)
  );

  cfg_crc8 u_crc_b (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (config_data_inB),
    .crc    (crc_b)
  );
`else
  logic unused_tail;
  assign unused_tail     = config_data_outA ^ config_data_outB;
  assign config_data_inA = din_a_q;
  assign config_data_inB = din_b_q;
`endif

  assign s_ready     = s_ready_q;
  assign config_en   = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
